vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- VGA raster timing generator; sits directly upstream of the pixel renderer inside tt_um_sleepwell.
- Produces hsync/vsync plus the current beam position (hpos/vpos), the active-video flag, and line/frame strobes.
- The renderer consumes these to compute RGB. The sync outputs also drive uo_out.
- Default timing is 640x480@60 from a 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active sync level (0 = active-low, as 640x480 requires)
- CNT_W, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high; top level drives it from ~rst_n
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high when the beam is in the visible area
- hpos  out  CNT_W  horizontal position, 0..H_TOTAL-1
- vpos  out  CNT_W  vertical position, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe when hpos==0
- frame_start  out  1  one-cycle strobe when hpos==0 and vpos==0
- frame_cnt  out  8  frame counter, wraps 255->0
- pix_en  out  1  pixel advance qualifier for downstream logic

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- All outputs are registered and mutually aligned: every output in a given cycle describes the same (hpos, vpos).
- While rst=1:
  - hpos=0, vpos=0, frame_cnt=0.
  - hsync=vsync=inactive (~SYNC_POL), display_on=0, line_start=0, frame_start=0.
- First cycle after rst falls: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Counting, on each cycle with pix_en=1:
  - hpos increments.
  - When hpos==H_TOTAL-1 it wraps to 0 and vpos increments.
  - When vpos==V_TOTAL-1 at that same wrap, vpos wraps to 0 and frame_cnt increments (modulo 256).
- hsync = SYNC_POL while H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL while V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491), for entire lines; otherwise ~SYNC_POL.
- display_on = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
- line_start and frame_start last exactly one pix_en-qualified cycle.
- Reset mid-frame: on the next clock, everything returns to the reset values above. No partial sync pulse may persist past the reset cycle.
- No illegal counter states: hpos never reaches H_TOTAL, vpos never reaches V_TOTAL.

Optional Feature:
- Macro: VGA_TIMING_PIX_DIV2_EN.
- Defined:
  - An internal toggle, reset to 0, drives pix_en; counters and strobes advance only when pix_en=1.
  - This supports a 50 MHz clk. Each hpos value is held for 2 clocks; strobes last 1 clock.
  - After reset release, hpos=0 persists 2 clocks.
- Undefined: pix_en is tied to 1, and counters advance every clock.

Decomposition:
- vga_timing_pkg holds:
  - default timing constants (H_/V_ ACTIVE/FP/SYNC/BP)
  - derived H_TOTAL and V_TOTAL
  - CNT_W
  - SYNC_POL default
- Sub-module vga_axis_counter is instantiated twice (horizontal, vertical). It provides:
  - enable input
  - wrap-at-TOTAL-1 with a wrap pulse output
  - sync-window decode and active-window decode
- The vertical instance is enabled by the horizontal wrap pulse ANDed with pix_en.

Test Plan:
- Reset: hold rst 5 clocks -> hsync=vsync=1, display_on=0, hpos=vpos=0, frame_cnt=0. Release -> first cycle frame_start=1, line_start=1, display_on=1.
- Horizontal sync window: run one line -> hsync=0 exactly for hpos 656..751 (96 clocks); display_on falls at hpos 640; hpos wraps 799->0 with vpos 0->1 and line_start=1.
- Frame wrap: run to (799,524) -> next cycle (0,0), frame_start=1, frame_cnt 0->1. vsync=0 for exactly 1600 clocks (lines 490-491).
- Full frame: count display_on=1 cycles over 420000 clocks -> 307200; count line_start pulses -> 525.
- Mid-frame reset: assert rst at (300,200) for 1 clock -> next cycle reset values. Reassert rst during the hsync window -> hsync returns to 1 on the next clock.
- With VGA_TIMING_PIX_DIV2_EN: each hpos value is held 2 clocks; line period is 1600 clocks; line_start is high 1 clock per line.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Default 640x480@60 raster constants shared by the timing generator and its
// axis counters. The DEF_ values are the defaults of the top-level parameters;
// a different mode can be built by overriding those parameters.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int   DEF_CNT_W    = 10;
  localparam logic DEF_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a counter that wraps at TOTAL-1, plus registered decodes of
// the sync window and the active window. The decodes are computed from the
// next count value so that they line up with the registered count.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        load 0 on the next clock (first cycle after reset release)
//   en         advance the counter on this clock
//   count      current position, 0..TOTAL-1
//   wrap       count is at TOTAL-1 (next advance wraps to 0)
//   in_sync    count is inside [SYNC_START, SYNC_END)
//   in_active  count is below ACTIVE
module vga_axis_counter #(
  parameter int W          = 10,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_active
);

  logic [W-1:0] count_next;

  assign wrap = (count == W'(TOTAL - 1));

  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (en)
      count_next = wrap ? '0 : count + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      in_sync   <= 1'b0;
      in_active <= 1'b0;
    end else begin
      count     <= count_next;
      in_sync   <= (count_next >= W'(SYNC_START)) && (count_next < W'(SYNC_END));
      in_active <= (count_next < W'(ACTIVE));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator feeding the pixel renderer. Produces sync pulses,
// the beam position, the visible-area flag and line/frame strobes, all taken
// from flops so every output in a cycle describes the same (hpos, vpos).
// Optional build macro VGA_TIMING_PIX_DIV2_EN: pixel advance every other clock
// (50 MHz clk); otherwise pix_en is tied high and the beam advances every clock.
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   hsync/vsync  sync outputs, active level SYNC_POL
//   display_on   beam in visible area
//   hpos/vpos    beam position
//   line_start   strobe at hpos==0
//   frame_start  strobe at hpos==0, vpos==0
//   frame_cnt    frame counter, wraps 255->0
//   pix_en       pixel advance qualifier
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic             pix_en
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // run_reg is low only in the first clock after reset release; that clock
  // loads position (0,0) with its strobes instead of advancing.
  logic       run_reg;
  logic       start;
  logic       step;
  logic       h_wrap, v_wrap;
  logic       h_sync_on, v_sync_on;
  logic       h_act, v_act;
  logic       line_start_reg, frame_start_reg;
  logic [7:0] frame_cnt_reg;

  assign start = ~run_reg;

`ifdef VGA_TIMING_PIX_DIV2_EN
  // pix_en marks the first clock of each two-clock pixel. The beam moves on
  // the edge that leads into a pix_en=1 clock, so strobes coincide with it.
  logic pix_en_reg;

  always_ff @(posedge clk) begin
    if (rst)
      pix_en_reg <= 1'b0;
    else
      pix_en_reg <= ~pix_en_reg;
  end

  assign pix_en = pix_en_reg;
  assign step   = run_reg & ~pix_en_reg;
`else
  assign pix_en = 1'b1;
  assign step   = run_reg;
`endif

  vga_axis_counter #(
    .W          (CNT_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        (step),
    .count     (hpos),
    .wrap      (h_wrap),
    .in_sync   (h_sync_on),
    .in_active (h_act)
  );

  vga_axis_counter #(
    .W          (CNT_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        (step & h_wrap),
    .count     (vpos),
    .wrap      (v_wrap),
    .in_sync   (v_sync_on),
    .in_active (v_act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg         <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= 8'd0;
    end else begin
      run_reg         <= 1'b1;
      line_start_reg  <= start | (step & h_wrap);
      frame_start_reg <= start | (step & h_wrap & v_wrap);
      if (step & h_wrap & v_wrap)
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  // Sync flags are flops; only the polarity select sits after them.
  assign hsync       = h_sync_on ? SYNC_POL : ~SYNC_POL;
  assign vsync       = v_sync_on ? SYNC_POL : ~SYNC_POL;
  assign display_on  = h_act & v_act;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Bench for vga_timing_gen. Two instances share clock and reset: a small
// geometry (12x7 total) so whole frames and the 256-frame counter wrap fit in a
// short run, and the default 640x480 geometry for the horizontal timing.
// Expected outputs come from a position model: the beam position is derived
// from the number of clocks since reset release with plain division/modulo.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIX_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // small geometry
  localparam int SHA = 8, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT * DIV;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic       pix_en;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s_hsync, s_vsync, s_disp, s_ls, s_fs, s_pix;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_fc;
  logic       d_hsync, d_vsync, d_disp, d_ls, d_fs, d_pix;
  logic [9:0] d_hpos, d_vpos;
  logic [7:0] d_fc;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) dut_small (
    .clk(clk), .rst(rst), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_disp), .hpos(s_hpos), .vpos(s_vpos),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc), .pix_en(s_pix)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_disp), .hpos(d_hpos), .vpos(d_vpos),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc), .pix_en(d_pix)
  );

  outs_t got_s, got_d;
  assign got_s = {s_hsync, s_vsync, s_disp, s_hpos, s_vpos, s_ls, s_fs, s_fc, s_pix};
  assign got_d = {d_hsync, d_vsync, d_disp, d_hpos, d_vpos, d_ls, d_fs, d_fc, d_pix};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k clocks after reset release (k<0: reset held).
  function automatic outs_t model(input int k, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb);
    outs_t o;
    int ht, vt, p, h, v, ln;
    logic first;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (k < 0) begin
      o = '0;
      o.hsync = 1'b1;
      o.vsync = 1'b1;
      o.pix_en = (DIV == 1);
      return o;
    end
    p     = k / DIV;
    first = (k % DIV) == 0;
    h     = p % ht;
    ln    = p / ht;
    v     = ln % vt;
    o.hpos        = 10'(h);
    o.vpos        = 10'(v);
    o.frame_cnt   = 8'((ln / vt) % 256);
    o.hsync       = !(h >= ha + hf && h < ha + hf + hs);
    o.vsync       = !(v >= va + vf && v < va + vf + vs);
    o.display_on  = (h < ha) && (v < va);
    o.line_start  = first && (h == 0);
    o.frame_start = first && (h == 0) && (v == 0);
    o.pix_en      = (DIV == 1) ? 1'b1 : first;
    return o;
  endfunction

  // Clocks since reset release, as seen by the outputs after each edge.
  int k = -1;
  always @(posedge clk) k <= rst ? -1 : k + 1;

  logic chk_en = 1'b0;
  int   mism_s = 0;
  int   mism_d = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      outs_t es, ed;
      es = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      ed = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
      if (got_s !== es) begin
        if (mism_s == 0) check("cycle_small", 64'(got_s), 64'(es));
        mism_s++;
      end
      if (got_d !== ed) begin
        if (mism_d == 0) check("cycle_default", 64'(got_d), 64'(ed));
        mism_d++;
      end
    end
  end

  task automatic release_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int disp, ls, vlow, hlow, n, gap, hold;

    // reset held 5 clocks
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_hsync", s_hsync, 1);
    check("rst_vsync", s_vsync, 1);
    check("rst_display", s_disp, 0);
    check("rst_hpos", s_hpos, 0);
    check("rst_vpos", s_vpos, 0);
    check("rst_frame_cnt", s_fc, 0);
    check("rst_line_start", s_ls, 0);

    // first cycle after release
    rst = 1'b0;
    @(negedge clk);
    check("rel_frame_start", s_fs, 1);
    check("rel_line_start", s_ls, 1);
    check("rel_display", s_disp, 1);
    check("rel_hpos", s_hpos, 0);

    // one full small frame of statistics
    disp = 0; ls = 0; vlow = 0; hlow = 0;
    for (int i = 0; i < SFRAME; i++) begin
      disp += s_disp;
      ls   += s_ls;
      vlow += !s_vsync;
      hlow += !s_hsync;
      @(negedge clk);
    end
    check("frame_display_cycles", disp, SHA * SVA * DIV);
    check("frame_line_starts", ls, SVT);
    check("frame_vsync_low", vlow, SVS * SHT * DIV);
    check("frame_hsync_low", hlow, SHS * SVT * DIV);
    check("frame_wrap_cnt", s_fc, 1);
    check("frame_wrap_start", s_fs, 1);

    // default geometry: two lines
    release_reset();
    disp = 0; ls = 0; hlow = 0;
    for (int i = 0; i < 1600 * DIV; i++) begin
      disp += d_disp;
      ls   += d_ls;
      hlow += !d_hsync;
      @(negedge clk);
    end
    check("def_hsync_low", hlow, 192 * DIV);
    check("def_display_cycles", disp, 1280 * DIV);
    check("def_line_starts", ls, 2);
    check("def_vpos_after_2_lines", d_vpos, 2);
    check("def_hpos_after_2_lines", d_hpos, 0);

    // frame counter through its 255->0 wrap
    release_reset();
    repeat (SFRAME - 1) @(negedge clk);
    check("last_px_hpos", s_hpos, SHT - 1);
    check("last_px_vpos", s_vpos, SVT - 1);
    check("last_px_fc", s_fc, 0);
    @(negedge clk);
    check("f1_hpos", s_hpos, 0);
    check("f1_vpos", s_vpos, 0);
    check("f1_fc", s_fc, 1);
    repeat (255 * SFRAME - 1) @(negedge clk);
    check("fc_255", s_fc, 255);
    @(negedge clk);
    check("fc_wrap_0", s_fc, 0);
    check("fc_wrap_start", s_fs, 1);

    // mid-frame reset at a chosen position
    n = 0;
    while (!(s_hpos == 10'd5 && s_vpos == 10'd3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_mid_pos", n < 400, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_hpos", s_hpos, 0);
    check("mid_rst_vpos", s_vpos, 0);
    check("mid_rst_display", s_disp, 0);
    check("mid_rst_fc", s_fc, 0);
    rst = 1'b0;
    @(negedge clk);

    // reset inside the hsync window must end the pulse at once
    n = 0;
    while (s_hsync !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_hsync", n < 400, 1);
    rst = 1'b1;
    @(negedge clk);
    check("hsync_rst_release", s_hsync, 1);
    rst = 1'b0;

    // random reset pulses; the per-cycle model check covers the rest
    for (int it = 0; it < 40; it++) begin
      gap  = $urandom_range(0, 300);
      hold = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      rst = 1'b1;
      repeat (hold) @(negedge clk);
      rst = 1'b0;
    end
    repeat (SFRAME + 20) @(negedge clk);

    check("cycle_mismatches_small", mism_s, 0);
    check("cycle_mismatches_default", mism_d, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
